// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding selects and the
// per-stage shadow record kept for ID/EX, EX/MEM and MEM/WB.
package pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_EXM = 2'b10;

    // Widest register address a shadow can hold; narrower RA_W values are zero-extended.
    localparam int RA_MAX = 8;

    typedef struct packed {
        logic              valid;
        logic [RA_MAX-1:0] rd;
        logic              regwe;
        logic              memread;
        logic              memacc;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
// Latency: count visible one cycle after inc_i; no backpressure.
// Async active-low clear.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding/stage-valid controller for the 5-stage RV32I pipe.
// Latency: all controls combinational from shadow state + inputs; shadows update next edge.
// Backpressure: a MEM access without dmem_ready freezes IF..MEM and bubbles MEM/WB.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int RA_W     = 5,
    parameter int CNT_W    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_regwe,
    input  logic             id_memread,
    input  logic             id_memacc,
    input  logic             if_valid,
    input  logic [RA_W-1:0]  ex_rs1,
    input  logic [RA_W-1:0]  ex_rs2,
    input  logic             ex_redirect,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             v_ex,
    output logic             v_mem,
    output logic             v_wb,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    stage_t ex_q, ex_d;
    stage_t mem_q, mem_d;
    stage_t wb_q, wb_d;

    logic freeze;
    logic redirect;
    logic lu_hit;
    logic load_use;

    // A stage produces register r if it is live, writes, and r is not the hardwired zero.
    function automatic logic hit(input stage_t s, input logic [RA_W-1:0] r);
        logic zero_blk;
        zero_blk = (ZERO_REG != 0) && (s.rd == '0);
        return s.valid && s.regwe && (s.rd == RA_MAX'(r)) && !zero_blk;
    endfunction

    // A load still in EX/MEM has no data yet, so it can only be picked up from MEM/WB.
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] r);
        if (hit(mem_q, r) && !mem_q.memread) begin
            return FWD_EXM;
        end else if (hit(wb_q, r)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    assign lu_hit   = ex_q.memread &&
                      ((id_use1 && hit(ex_q, id_rs1)) || (id_use2 && hit(ex_q, id_rs2)));
    assign freeze   = mem_q.valid && mem_q.memacc && !dmem_ready;
    assign redirect = !freeze && ex_redirect && ex_q.valid;
    assign load_use = !freeze && !redirect && lu_hit;

    assign pc_en       = !freeze && !load_use;
    assign ifid_en     = !freeze && !load_use;
    assign ifid_flush  = redirect;
    assign idex_en     = !freeze;
    assign idex_flush  = redirect || load_use;
    assign exmem_en    = !freeze;
    assign memwb_flush = freeze;

    assign fwd_a = fwd_sel(ex_rs1);
    assign fwd_b = fwd_sel(ex_rs2);

    assign v_ex  = ex_q.valid;
    assign v_mem = mem_q.valid;
    assign v_wb  = wb_q.valid;

    always_comb begin
        ex_d = ex_q;
        if (idex_en) begin
            if (idex_flush) begin
                ex_d = STAGE_BUBBLE;
            end else begin
                ex_d.valid   = if_valid;
                ex_d.rd      = RA_MAX'(id_rd);
                ex_d.regwe   = if_valid && id_regwe;
                ex_d.memread = if_valid && id_memread;
                ex_d.memacc  = if_valid && id_memacc;
            end
        end
    end

    assign mem_d = exmem_en    ? ex_q         : mem_q;
    assign wb_d  = memwb_flush ? STAGE_BUBBLE : mem_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= STAGE_BUBBLE;
            mem_q <= STAGE_BUBBLE;
            wb_q  <= STAGE_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (!pc_en),
        .cnt_o  (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (redirect),
        .cnt_o  (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed per-cycle vector table, reset/saturation
// sequences, then random traffic against a queue-style pipeline model.
module tb_pipe_hazard_ctrl;

    localparam int CW  = 4;
    localparam int SAT = 15;

    localparam logic [6:0] N  = 7'b1101010;
    localparam logic [6:0] LU = 7'b0001110;
    localparam logic [6:0] RD = 7'b1111110;
    localparam logic [6:0] FZ = 7'b0000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, id_rd = '0, ex_rs1 = '0, ex_rs2 = '0;
    logic          id_use1 = 0, id_use2 = 0, id_regwe = 0, id_memread = 0, id_memacc = 0;
    logic          if_valid = 0, ex_redirect = 0, dmem_ready = 0;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
    logic [1:0]    fwd_a, fwd_b;
    logic          v_ex, v_mem, v_wb;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [21:0]   obs;

    pipe_hazard_ctrl #(.RA_W(5), .CNT_W(CW), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .id_rd(id_rd), .id_regwe(id_regwe), .id_memread(id_memread), .id_memacc(id_memacc),
        .if_valid(if_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_redirect(ex_redirect), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
        .memwb_flush(memwb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .v_ex(v_ex), .v_mem(v_mem), .v_wb(v_wb),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush,
                  fwd_a, fwd_b, v_ex, v_mem, v_wb, stall_cnt, flush_cnt};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [21:0] act, input logic [21:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    function automatic logic [21:0] exp_of(input logic [6:0] ctl, input int fa, input int fb,
                                           input logic [2:0] v, input int sc, input int fc);
        return {ctl, 2'(fa), 2'(fb), v, 4'(sc), 4'(fc)};
    endfunction

    // flags: {use1, use2, regwe, memread, memacc, if_valid, ex_redirect, dmem_ready}
    typedef struct packed {
        logic       rst_b4;
        logic [4:0] rs1, rs2, rd;
        logic [7:0] fl;
        logic [4:0] ers1, ers2;
        logic [6:0] ctl;
        logic [1:0] fa, fb;
        logic [2:0] v;
        logic [3:0] sc, fc;
    } vec_t;

    vec_t vq[$];

    task automatic row(input bit b, input int rs1, input int rs2, input int rd,
                       input logic [7:0] fl, input int e1, input int e2, input logic [6:0] ctl,
                       input int fa, input int fb, input logic [2:0] v, input int sc, input int fc);
        vec_t r;
        r.rst_b4 = b;   r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd); r.fl = fl;
        r.ers1 = 5'(e1); r.ers2 = 5'(e2); r.ctl = ctl; r.fa = 2'(fa); r.fb = 2'(fb);
        r.v = v; r.sc = 4'(sc); r.fc = 4'(fc);
        vq.push_back(r);
    endtask

    task automatic apply(input int rs1, input int rs2, input int rd, input logic [7:0] fl,
                         input int e1, input int e2);
        id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
        ex_rs1 = 5'(e1);  ex_rs2 = 5'(e2);
        {id_use1, id_use2, id_regwe, id_memread, id_memacc, if_valid, ex_redirect, dmem_ready} = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Reference: index 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB, advanced like a shift queue.
    int m_v[3], m_rd[3], m_we[3], m_ld[3], m_ma[3];
    int m_sc, m_fc;

    task automatic m_clear();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 0; m_rd[i] = 0; m_we[i] = 0; m_ld[i] = 0; m_ma[i] = 0;
        end
        m_sc = 0;
        m_fc = 0;
    endtask

    function automatic bit m_hit(input int s, input int r);
        return m_v[s] != 0 && m_we[s] != 0 && m_rd[s] == r && r != 0;
    endfunction

    function automatic int m_fwd(input int r);
        if (m_hit(1, r) && m_ld[1] == 0) return 2;
        if (m_hit(2, r)) return 1;
        return 0;
    endfunction

    task automatic m_decide(output bit fz, output bit rdr, output bit lu);
        fz  = m_v[1] != 0 && m_ma[1] != 0 && !dmem_ready;
        rdr = !fz && ex_redirect && m_v[0] != 0;
        lu  = !fz && !rdr && m_v[0] != 0 && m_ld[0] != 0 &&
              ((id_use1 && m_hit(0, int'(id_rs1))) || (id_use2 && m_hit(0, int'(id_rs2))));
    endtask

    task automatic m_expect(output logic [21:0] e);
        bit fz, rdr, lu;
        logic [6:0] ctl;
        m_decide(fz, rdr, lu);
        ctl = fz ? FZ : rdr ? RD : lu ? LU : N;
        e = exp_of(ctl, m_fwd(int'(ex_rs1)), m_fwd(int'(ex_rs2)),
                   {m_v[0] != 0, m_v[1] != 0, m_v[2] != 0}, m_sc, m_fc);
    endtask

    task automatic m_step();
        bit fz, rdr, lu;
        m_decide(fz, rdr, lu);
        if ((fz || lu) && m_sc < SAT) m_sc++;
        if (rdr && m_fc < SAT) m_fc++;
        if (fz) begin
            m_v[2] = 0; m_rd[2] = 0; m_we[2] = 0; m_ld[2] = 0; m_ma[2] = 0;
        end else begin
            for (int i = 2; i > 0; i--) begin
                m_v[i] = m_v[i-1]; m_rd[i] = m_rd[i-1]; m_we[i] = m_we[i-1];
                m_ld[i] = m_ld[i-1]; m_ma[i] = m_ma[i-1];
            end
            if (rdr || lu) begin
                m_v[0] = 0; m_rd[0] = 0; m_we[0] = 0; m_ld[0] = 0; m_ma[0] = 0;
            end else begin
                m_v[0] = int'(if_valid); m_rd[0] = int'(id_rd); m_we[0] = int'(id_regwe);
                m_ld[0] = int'(id_memread); m_ma[0] = int'(id_memacc);
            end
        end
    endtask

    initial begin
        logic [21:0] e;

        // independent adds
        row(1, 2,3,1, 8'b11100101, 0,0, N, 0,0, 3'b000, 0,0);
        row(0, 5,6,4, 8'b11100101, 2,3, N, 0,0, 3'b100, 0,0);
        row(0, 0,0,0, 8'b00000001, 5,6, N, 0,0, 3'b110, 0,0);
        row(0, 0,0,0, 8'b00000001, 0,0, N, 0,0, 3'b011, 0,0);
        // add x5 ; sub x7,x5,x5
        row(1, 2,3,5, 8'b11100101, 0,0, N, 0,0, 3'b000, 0,0);
        row(0, 5,5,7, 8'b11100101, 2,3, N, 0,0, 3'b100, 0,0);
        row(0, 0,0,0, 8'b00000001, 5,5, N, 2,2, 3'b110, 0,0);
        row(0, 0,0,0, 8'b00000001, 5,5, N, 1,1, 3'b011, 0,0);
        // lw x5 ; add x6,x5,x0
        row(1, 1,0,5, 8'b10111101, 0,0, N,  0,0, 3'b000, 0,0);
        row(0, 5,0,6, 8'b11100101, 1,0, LU, 0,0, 3'b100, 0,0);
        row(0, 5,0,6, 8'b11100101, 0,0, N,  0,0, 3'b010, 1,0);
        row(0, 0,0,0, 8'b00000001, 5,0, N,  1,0, 3'b101, 1,0);
        // redirect in the same cycle as a load-use
        row(1, 1,0,5, 8'b10111101, 0,0, N,  0,0, 3'b000, 0,0);
        row(0, 5,5,6, 8'b11100111, 1,0, RD, 0,0, 3'b100, 0,0);
        row(0, 0,0,0, 8'b00000001, 0,0, N,  0,0, 3'b010, 0,1);
        // store waits 3 cycles for dmem
        row(1, 1,2,0, 8'b11001101, 0,0, N,  0,0, 3'b000, 0,0);
        row(0, 0,0,0, 8'b00000001, 1,2, N,  0,0, 3'b100, 0,0);
        row(0, 0,0,0, 8'b00000000, 0,0, FZ, 0,0, 3'b010, 0,0);
        row(0, 0,0,0, 8'b00000000, 0,0, FZ, 0,0, 3'b010, 1,0);
        row(0, 0,0,0, 8'b00000000, 0,0, FZ, 0,0, 3'b010, 2,0);
        row(0, 0,0,0, 8'b00000001, 0,0, N,  0,0, 3'b010, 3,0);
        row(0, 0,0,0, 8'b00000001, 0,0, N,  0,0, 3'b001, 3,0);
        // writes to x0 never forward or stall
        row(1, 1,0,0, 8'b10111101, 0,0, N, 0,0, 3'b000, 0,0);
        row(0, 0,0,0, 8'b10100101, 1,0, N, 0,0, 3'b100, 0,0);
        row(0, 0,0,1, 8'b11100101, 0,0, N, 0,0, 3'b110, 0,0);
        row(0, 0,0,0, 8'b00000001, 0,0, N, 0,0, 3'b111, 0,0);

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst_b4) do_reset();
            apply(int'(vq[i].rs1), int'(vq[i].rs2), int'(vq[i].rd), vq[i].fl,
                  int'(vq[i].ers1), int'(vq[i].ers2));
            @(negedge clk);
            chk($sformatf("vec%0d", i), obs,
                exp_of(vq[i].ctl, int'(vq[i].fa), int'(vq[i].fb), vq[i].v,
                       int'(vq[i].sc), int'(vq[i].fc)));
            tick();
        end

        // reset asserted in the middle of a freeze
        do_reset();
        apply(1,2,0, 8'b11001101, 0,0); tick();
        apply(0,0,0, 8'b00000001, 1,2); tick();
        apply(0,0,0, 8'b00000000, 0,0);
        @(negedge clk);
        chk("frz_pre", obs, exp_of(FZ, 0,0, 3'b010, 0,0));
        #2 rst = 1'b0;
        #1 chk("frz_rst", obs, exp_of(N, 0,0, 3'b000, 0,0));
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("frz_after", obs, exp_of(N, 0,0, 3'b000, 0,0));
        tick();

        // stall counter saturates during a long freeze
        do_reset();
        apply(1,2,0, 8'b11001101, 0,0); tick();
        apply(0,0,0, 8'b00000001, 1,2); tick();
        apply(0,0,0, 8'b00000000, 0,0);
        repeat (20) tick();
        @(negedge clk);
        chk("sat_hold", obs, exp_of(FZ, 0,0, 3'b010, SAT, 0));
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("sat_release", obs, exp_of(N, 0,0, 3'b001, SAT, 0));
        tick();

        // random traffic against the model
        do_reset();
        m_clear();
        for (int c = 0; c < 3000; c++) begin
            apply(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  {6'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0},
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            @(negedge clk);
            m_expect(e);
            chk($sformatf("rand%0d", c), obs, e);
            m_step();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Centralised hazard, forwarding and stage-valid controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Holds its own shadow scoreboard (valid, rd, regwe, memread) for the ID/EX, EX/MEM and MEM/WB registers.
- Drives every pipeline-register enable/flush and both EX operand forwarding selects.
- Over the current ad-hoc stall logic it adds: data-memory wait states (dmem_ready handshake), parametrised register-address width, and saturating stall/flush performance counters.

Parameters:
- RA_W, 5, register address width (2**RA_W architectural registers).
- CNT_W, 32, width of each performance counter.
- ZERO_REG, 1, if 1 register 0 is hardwired: never a forwarding or load-use match.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1  in  RA_W  source 1 of instruction in IF/ID.
- id_rs2  in  RA_W  source 2 of instruction in IF/ID.
- id_use1  in  1  ID instruction reads rs1.
- id_use2  in  1  ID instruction reads rs2.
- id_rd  in  RA_W  destination of ID instruction.
- id_regwe  in  1  ID instruction writes rd.
- id_memread  in  1  ID instruction is a load.
- id_memacc  in  1  ID instruction is a load or store.
- if_valid  in  1  IF/ID holds a real instruction (0 = bubble).
- ex_rs1  in  RA_W  rs1 held in ID/EX.
- ex_rs2  in  RA_W  rs2 held in ID/EX.
- ex_redirect  in  1  EX resolved a taken branch/jal/jalr.
- dmem_ready  in  1  data memory completes the access in MEM this cycle.
- pc_en  out  1  PC load enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads NOP.
- idex_en  out  1  ID/EX load enable.
- idex_flush  out  1  ID/EX loads bubble.
- exmem_en  out  1  EX/MEM load enable.
- memwb_flush  out  1  MEM/WB loads bubble.
- fwd_a  out  2  EX operand A select: 00 regfile, 01 MEM/WB result, 10 EX/MEM aluout.
- fwd_b  out  2  EX operand B select, same encoding.
- v_ex  out  1  ID/EX holds a real instruction.
- v_mem  out  1  EX/MEM holds a real instruction.
- v_wb  out  1  MEM/WB holds a real instruction.
- stall_cnt  out  CNT_W  cycles with pc_en = 0.
- flush_cnt  out  CNT_W  redirect flushes taken.

Behaviour:
- Reset (rst = 0, async): all valids, scoreboard fields and counters clear to 0. Outputs then resolve to an empty pipe: all enables 1, flushes 0, fwd 00.
- Shadow stages advance on the same enables/flushes the block drives. A bubble clears the valid bit, which also clears regwe and memread.
- Match rule, per ID source s: match(stage) = id_use_s & v_stage & regwe_stage & (rd_stage == s) & !(ZERO_REG & rd_stage == 0).
- freeze = v_mem & memacc_mem & !dmem_ready.
  - pc_en, ifid_en, idex_en, exmem_en = 0; memwb_flush = 1.
  - Redirect, load-use and counters other than stall_cnt are ignored while frozen.
- redirect (not frozen, ex_redirect & v_ex):
  - ifid_flush = 1, idex_flush = 1, pc_en = 1.
  - flush_cnt += 1.
  - Redirect beats load-use in the same cycle.
- load_use (not frozen, no redirect): v_ex & memread_ex & match(ex) on either source.
  - pc_en = 0, ifid_en = 0, idex_flush = 1.
  - Exactly one bubble; the load then sits in MEM and is forwarded from MEM/WB.
- Forwarding, evaluated with ex_rs1/ex_rs2 against the EX/MEM and MEM/WB shadows:
  - EX/MEM wins when it matches and is not a load (10).
  - Otherwise MEM/WB matches (01).
  - Otherwise 00.
  - A load in EX/MEM never selects 10.
- Counters saturate at all-ones and never wrap.
- Latency: all control outputs are combinational from the current state and inputs. Scoreboard updates take effect at the next edge.
- Reset deasserted mid-freeze: the state is already cleared, so no freeze is pending.

Decomposition:
- Shared package pipe_pkg: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_EXM = 2'b10; the stage-shadow struct {valid, rd, regwe, memread, memacc}.
- One sub-module, sat_counter (CNT_W wide, increment enable, async active-low clear), instantiated twice.

Test Plan:
- Independent adds (x1=x2+x3, x4=x5+x6) -> fwd_a = fwd_b = 00; all enables 1; stall_cnt stays 0.
- add x5,... then sub x7,x5,x5 back-to-back -> in sub's EX cycle fwd_a = fwd_b = 10.
- lw x5 then add x6,x5,x0 -> one cycle with pc_en = 0, idex_flush = 1; next cycle fwd_a = 01; stall_cnt = 1.
- Taken beq in EX in the same cycle as a load-use in ID -> ifid_flush = idex_flush = 1, pc_en = 1; flush_cnt = 1; no stall.
- Store in MEM with dmem_ready low for 3 cycles -> 3 cycles of all enables 0 and memwb_flush = 1; v_wb = 0 after; stall_cnt = 3.
- Writes to x0 followed by a reader with ZERO_REG = 1 -> fwd 00 and no stall. Assert rst low mid-freeze -> all outputs return to empty-pipe values immediately.
